// File: rtl/param_fifo.sv
// Parameterised single-clock FIFO with show-ahead read and level flags.
// Optional sticky overflow/underflow flags: define PARAM_FIFO_ERR_FLAGS_EN.
module param_fifo #(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 64,
  parameter int AF_LEVEL = DEPTH - 4,
  parameter int AE_LEVEL = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     wen,
  output logic [WIDTH-1:0]         rdata,
  input  logic                     ren,
  input  logic                     flush,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] AF_TH = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_TH = CW'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW:0] wptr;
  logic [AW:0] rptr;
  logic        wvalid;
  logic        rvalid;

  // Accepted transfers: flush swallows both requests.
  assign wvalid = wen & ~full  & ~flush;
  assign rvalid = ren & ~empty & ~flush;

  // Status from registered pointers; wrap bit separates full from empty.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);

  // Level flags from the registered occupancy.
  assign almost_full  = (count >= AF_TH);
  assign almost_empty = (count <= AE_TH);

  // Show-ahead head word.
  assign rdata = mem[rptr[AW-1:0]];

  // Storage is not reset; only accepted writes touch it.
  always_ff @(posedge clk) begin
    if (wvalid) begin
      mem[wptr[AW-1:0]] <= wdata;
    end
  end

  // Write pointer: advance on accepted write, clear on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
    end else if (flush) begin
      wptr <= '0;
    end else if (wvalid) begin
      wptr <= wptr + 1'b1;
    end
  end

  // Read pointer: advance on accepted read, clear on flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr <= '0;
    end else if (flush) begin
      rptr <= '0;
    end else if (rvalid) begin
      rptr <= rptr + 1'b1;
    end
  end

  // Occupancy tracks wptr - rptr, updated alongside the pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      unique case ({wvalid, rvalid})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef PARAM_FIFO_ERR_FLAGS_EN
  // Sticky overflow: write attempted while full, held until flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (flush) begin
      overflow <= 1'b0;
    end else if (wen && full) begin
      overflow <= 1'b1;
    end
  end

  // Sticky underflow: read attempted while empty, held until flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      underflow <= 1'b0;
    end else if (flush) begin
      underflow <= 1'b0;
    end else if (ren && empty) begin
      underflow <= 1'b1;
    end
  end
`else
  assign overflow  = 1'b0;
  assign underflow = 1'b0;
`endif

endmodule

// File: doc/param_fifo.md
PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 64, entry count; power of two, >=2.
REQ-003 SHALL have parameter AF_LEVEL, default DEPTH-4, almost-full threshold (1..DEPTH-1).
REQ-004 SHALL have parameter AE_LEVEL, default 4, almost-empty threshold (0..DEPTH-2).
REQ-005 SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have ports wdata (input, WIDTH, write data) and wen (input, 1, write request).
REQ-008 SHALL have ports rdata (output, WIDTH, head data) and ren (input, 1, read request).
REQ-009 SHALL have port flush, input, 1, synchronous clear of all contents.
REQ-010 SHALL have outputs full, empty, almost_full, almost_empty (each 1 bit).
REQ-011 SHALL have output count, $clog2(DEPTH)+1 bits, current occupancy 0..DEPTH.
REQ-012 SHALL have outputs overflow and underflow, 1 bit each, sticky error flags.

Function
REQ-013 SHALL accept a write (wvalid) iff wen=1 and full=0 and flush=0; store wdata at write pointer, advance it by 1.
REQ-014 SHALL accept a read (rvalid) iff ren=1 and empty=0 and flush=0; advance read pointer by 1.
REQ-015 SHALL use pointers of $clog2(DEPTH)+1 bits; low bits index storage, MSB is wrap bit; wrap from DEPTH-1 to 0 silently.
REQ-016 SHALL present rdata combinationally from the entry at the read pointer (show-ahead, zero read latency); rdata is don't-care while empty.
REQ-017 SHALL drive empty=1 iff pointers are equal, full=1 iff low bits equal and wrap bits differ; both purely combinational from registered pointers.
REQ-018 SHALL update count registered: +1 on write-only, -1 on read-only, unchanged on both or neither; count = write pointer minus read pointer at all times.
REQ-019 SHALL drive almost_full=1 iff count>=AF_LEVEL, almost_empty=1 iff count<=AE_LEVEL.
REQ-020 SHALL, when full with wen=1 and ren=1, reject the write and perform the read (count DEPTH-1 next cycle).
REQ-021 SHALL, when empty with wen=1 and ren=1, perform the write and reject the read (count 1 next cycle; new word visible on rdata next cycle).
REQ-022 SHALL, on flush=1, set both pointers and count to 0 next edge, discarding wen/ren that cycle; storage contents not cleared.
REQ-023 SHALL first-word-fall-through: data written at edge N is readable on rdata after edge N when FIFO was empty.

Reset
REQ-024 SHALL on rst=1 immediately (no clock) clear pointers and count to 0, giving empty=1, full=0, almost_empty=1, almost_full=0, overflow=0, underflow=0.
REQ-025 SHALL not reset storage array; rdata undefined until first write after reset.
REQ-026 SHALL, on rst asserted mid-operation, discard all contents; first accepted write after deassertion lands in entry 0.

Configuration
REQ-027 SHALL compile sticky error detection only when macro PARAM_FIFO_ERR_FLAGS_EN is defined: overflow set on wen=1 while full=1, underflow set on ren=1 while empty=1, both held until rst or flush.
REQ-028 SHALL, without PARAM_FIFO_ERR_FLAGS_EN, keep the overflow/underflow ports but tie them to constant 0, with no error logic.

Verification
REQ-029 SHALL cover: reset, write 64 words 0..63 with DEPTH=64 -> full=1, count=64, almost_full asserted at count=60, word 64 rejected.
REQ-030 SHALL cover: from full, read 64 words -> rdata sequence 0..63, empty=1 after last read, almost_empty asserted at count=4.
REQ-031 SHALL cover: 200 writes/reads with continuous simultaneous wen/ren at count 10 -> count stays 10, data in order across pointer wrap.
REQ-032 SHALL cover: empty with wen=ren=1, wdata=0xA5A5 -> count=1, rdata=0xA5A5 next cycle; full with wen=ren=1 -> count=DEPTH-1.
REQ-033 SHALL cover: count=30, assert flush with wen=1 -> count=0, empty=1 next cycle; rst pulse between edges -> empty=1 before next edge.
REQ-034 SHALL cover (macro defined): wen=1 while full -> overflow=1 and held through 10 cycles until flush; macro undefined -> overflow=0, underflow=0 always.
